axi_sram_bridge: RTL and testbench

//   Converts mycpu_core's instruction and data SRAM-style ports into one AXI3 master with a single outstanding transaction.
//   - Sits directly downstream of the core and upstream of the SoC interconnect.
//   - Stalls the pipeline via one stall request while any enabled port's access is incomplete.
//   - Data port has priority over instruction port.

---
 rtl/axi_sram_bridge_if.sv | 66 ++++++
 rtl/axi_sram_bridge.sv | 197 +++++++++++++++++++
 tb/tb_axi_sram_bridge.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_sram_bridge_if
// Purpose  : AXI3 channel bundle between the SRAM bridge (master) and the
//            SoC interconnect (slave). len/burst/lock/cache/prot are tied
//            off in the SoC wrapper and are therefore not carried here.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_sram_bridge_if;
  // read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  // read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  // write data channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // write response channel
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arsize, arvalid,
    input  arready,
    input  rid, rdata, rlast, rvalid,
    output rready,
    output awid, awaddr, awsize, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arsize, arvalid,
    output arready,
    output rid, rdata, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awsize, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/axi_sram_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_sram_bridge
// Purpose  : Turns the core's instruction and data SRAM-style ports into a
//            single AXI3 master with one outstanding transaction. The data
//            port wins over the instruction port; the pipeline is stalled
//            until every enabled port has completed its access.
// Revision : 1.0 - initial release
// ============================================================================
module axi_sram_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_sram_en,
  input  logic [31:0]       inst_sram_addr,
  output logic [31:0]       inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              stallreq,
  axi_sram_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    D_AR = 3'd1,
    D_R  = 3'd2,
    D_W  = 3'd3,
    D_B  = 3'd4,
    I_AR = 3'd5,
    I_R  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_done_q, inst_done_d;
  logic        data_done_q, data_done_d;
  logic        aw_ok_q, aw_ok_d;
  logic        w_ok_q, w_ok_d;

  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [2:0]  awsize;
  logic        unused_ok;

  // Hold the pipeline while any enabled port still owes a completion.
  assign stallreq = ~rst & ((inst_sram_en & ~inst_done_q) |
                            (data_sram_en & ~data_done_q));

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  // Address/data fields come straight from the captured request.
  assign axi.arid    = (state_q == I_AR) ? INST_ID : DATA_ID;
  assign axi.araddr  = {addr_q[31:2], 2'b00};
  assign axi.arsize  = 3'd2;
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;
  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awsize  = awsize;
  assign axi.awvalid = awvalid;
  assign axi.wid     = DATA_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wen_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid;
  assign axi.bready  = bready;

  // rid is irrelevant with a single outstanding read; rlast is always set.
  assign unused_ok = ^{axi.rid, axi.rlast};

  // Write transfer size follows the byte-enable pattern (word/half/byte).
  always_comb begin
    awsize = 3'd0;
    case (wen_q)
      4'b1111:         awsize = 3'd2;
      4'b0011, 4'b1100: awsize = 3'd1;
      default:         awsize = 3'd0;
    endcase
  end

  // Next-state, capture and channel-handshake logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = inst_done_q;
    data_done_d  = data_done_q;
    aw_ok_d      = aw_ok_q;
    w_ok_d       = w_ok_q;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;

    // Once the pipeline is released the completed accesses are consumed.
    if (!stallreq) begin
      inst_done_d = 1'b0;
      data_done_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (data_sram_en && !data_done_q) begin
          addr_d  = data_sram_addr;
          wen_d   = data_sram_wen;
          wdata_d = data_sram_wdata;
          aw_ok_d = 1'b0;
          w_ok_d  = 1'b0;
          state_d = (|data_sram_wen) ? D_W : D_AR;
        end else if (inst_sram_en && !inst_done_q) begin
          addr_d  = inst_sram_addr;
          wen_d   = 4'b0000;
          state_d = I_AR;
        end
      end
      D_AR, I_AR: begin
        arvalid = 1'b1;
        if (axi.arready) state_d = (state_q == D_AR) ? D_R : I_R;
      end
      D_R: begin
        rready = 1'b1;
        if (axi.rvalid) begin
          data_rdata_d = axi.rdata;
          data_done_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      I_R: begin
        rready = 1'b1;
        if (axi.rvalid) begin
          inst_rdata_d = axi.rdata;
          inst_done_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      D_W: begin
        // AW and W retire independently; either may finish first or together.
        awvalid = ~aw_ok_q;
        wvalid  = ~w_ok_q;
        aw_ok_d = aw_ok_q | (awvalid & axi.awready);
        w_ok_d  = w_ok_q | (wvalid & axi.wready);
        if (aw_ok_d && w_ok_d) state_d = D_B;
      end
      D_B: begin
        bready = 1'b1;
        if (axi.bvalid) begin
          data_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      wen_q        <= 4'd0;
      wdata_q      <= 32'd0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      aw_ok_q      <= 1'b0;
      w_ok_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      aw_ok_q      <= aw_ok_d;
      w_ok_q       <= w_ok_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_bridge
// Purpose  : Self-checking bench for axi_sram_bridge: directed scenarios
//            followed by randomized mixed accesses against a word-level
//            memory model and AXI field rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;

  axi_sram_bridge_if axi ();

  axi_sram_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .axi             (axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // slave-side memory (written from what the DUT puts on the bus) and
  // reference memory (written from what the core asked for)
  logic [31:0] slave_mem [logic [29:0]];
  logic [31:0] ref_mem   [logic [29:0]];
  logic [31:0] exp_inst_rd = 32'd0;
  logic [31:0] exp_data_rd = 32'd0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [29:0] i);
    return {i, 2'b01} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [29:0] i);
    return slave_mem.exists(i) ? slave_mem[i] : dflt(i);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] i);
    return ref_mem.exists(i) ? ref_mem[i] : dflt(i);
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd);
    logic [31:0] w;
    w = ref_rd(a[31:2]);
    for (int b = 0; b < 4; b++) if (wen[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    ref_mem[a[31:2]] = w;
  endfunction

  // AXI transfer size implied by the number of bytes written
  function automatic logic [2:0] exp_awsize(input logic [3:0] wen);
    case ($countones(wen))
      4:       return 3'd2;
      2:       return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  // Acts as the interconnect for one transaction and checks its fields.
  task automatic serve(input bit is_data, input logic [31:0] addr, input logic [3:0] wen,
                       input logic [31:0] wdata, input int d1, input int d2, input int d3);
    int          n;
    int          c;
    bit          aw_done;
    bit          w_done;
    logic [29:0] idx;
    logic [31:0] word;
    n = 0;
    while (!axi.arvalid && !axi.awvalid && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(axi.arvalid | axi.awvalid), 32'd1);
    if (is_data && wen != 4'd0) begin
      check("aw_start", 32'({axi.awvalid, axi.wvalid, axi.arvalid}), 32'b110);
      check("awaddr", axi.awaddr, addr);
      check("awsize", 32'(axi.awsize), 32'(exp_awsize(wen)));
      check("wstrb", 32'(axi.wstrb), 32'(wen));
      check("wdata", axi.wdata, wdata);
      check("wlast_ids", 32'({axi.wlast, axi.awid, axi.wid}), 32'({1'b1, 4'd1, 4'd1}));
      idx  = axi.awaddr[31:2];
      word = slave_rd(idx);
      for (int b = 0; b < 4; b++) if (axi.wstrb[b]) word[b*8 +: 8] = axi.wdata[b*8 +: 8];
      slave_mem[idx] = word;
      aw_done = 1'b0;
      w_done  = 1'b0;
      c = 0;
      while (!(aw_done && w_done) && c < 40) begin
        check("awvalid_dw", 32'(axi.awvalid), 32'(!aw_done));
        check("wvalid_dw", 32'(axi.wvalid), 32'(!w_done));
        check("bready_dw", 32'(axi.bready), 32'd0);
        check("stall_dw", 32'(stallreq), 32'd1);
        axi.awready = !aw_done && c >= d1;
        axi.wready  = !w_done && c >= d2;
        tick();
        if (axi.awready) aw_done = 1'b1;
        if (axi.wready)  w_done  = 1'b1;
        c++;
      end
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      check("w_complete", 32'(aw_done && w_done), 32'd1);
      check("b_phase", 32'({axi.awvalid, axi.wvalid, axi.bready}), 32'b001);
      for (int k = 0; k < d3; k++) begin
        tick();
        check("bready_hold", 32'(axi.bready), 32'd1);
      end
      axi.bvalid = 1'b1;
      tick();
      axi.bvalid = 1'b0;
    end else begin
      check("ar_start", 32'({axi.arvalid, axi.awvalid, axi.wvalid}), 32'b100);
      check("araddr", axi.araddr, {addr[31:2], 2'b00});
      check("arid", 32'(axi.arid), is_data ? 32'd1 : 32'd0);
      check("arsize", 32'(axi.arsize), 32'd2);
      for (int k = 0; k < d1; k++) begin
        tick();
        check("ar_hold", 32'(axi.arvalid), 32'd1);
      end
      idx = axi.araddr[31:2];
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      check("r_phase", 32'({axi.arvalid, axi.rready}), 32'b01);
      for (int k = 0; k < d2; k++) begin
        tick();
        check("rready_hold", 32'({axi.rready, stallreq}), 32'b11);
      end
      axi.rdata  = slave_rd(idx);
      axi.rvalid = 1'b1;
      tick();
      axi.rvalid = 1'b0;
      axi.rdata  = 32'd0;
    end
  endtask

  // Present one request set from the core and see it through to release.
  task automatic access(input bit ie, input bit de, input logic [31:0] ia, input logic [31:0] da,
                        input logic [3:0] wen, input logic [31:0] wd,
                        input int d1, input int d2, input int d3);
    inst_sram_en    = ie;
    inst_sram_addr  = ia;
    data_sram_en    = de;
    data_sram_addr  = da;
    data_sram_wen   = wen;
    data_sram_wdata = wd;
    #1;
    check("stall_req", 32'(stallreq), 32'(ie | de));
    if (de) begin
      if (wen != 4'd0) ref_store(da, wen, wd);
      else exp_data_rd = ref_rd(da[31:2]);
      serve(1'b1, da, wen, wd, d1, d2, d3);
      check("data_rdata", data_sram_rdata, exp_data_rd);
      if (ie) begin
        check("stall_mid", 32'(stallreq), 32'd1);
        check("ar_gap", 32'(axi.arvalid), 32'd0);
      end
    end
    if (ie) begin
      exp_inst_rd = ref_rd(ia[31:2]);
      serve(1'b0, ia, 4'd0, 32'd0, d1, d2, d3);
      check("inst_rdata", inst_sram_rdata, exp_inst_rd);
    end
    check("stall_release", 32'(stallreq), 32'd0);
    inst_sram_en = 1'b0;
    data_sram_en = 1'b0;
    tick();
    check("stall_idle", 32'(stallreq), 32'd0);
    check("idle_valids", 32'({axi.arvalid, axi.awvalid, axi.wvalid}), 32'd0);
    check("rdata_hold", data_sram_rdata, exp_data_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    bit          ie;
    bit          de;
    int          kind;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  wen;
    logic [3:0]  wen_tab [10];

    wen_tab = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    rst = 1'b1;
    inst_sram_en = 1'b0;  inst_sram_addr = 32'd0;
    data_sram_en = 1'b0;  data_sram_wen  = 4'd0;
    data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    axi.arready = 1'b0; axi.rid = 4'd0; axi.rdata = 32'd0; axi.rlast = 1'b1;
    axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
    repeat (3) tick();
    check("rst_valids", 32'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}), 32'd0);
    check("rst_stall", 32'(stallreq), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_inst_rdata", inst_sram_rdata, 32'd0);
    check("rst_data_rdata", data_sram_rdata, 32'd0);
    check("idle_stall", 32'(stallreq), 32'd0);

    // instruction fetch with delayed arready and rvalid
    slave_mem[30'h2FF0_0000] = 32'h2408_0001;
    ref_mem[30'h2FF0_0000]   = 32'h2408_0001;
    access(1'b1, 1'b0, 32'hBFC0_0000, 32'd0, 4'd0, 32'd0, 2, 3, 0);
    check("t1_inst_word", inst_sram_rdata, 32'h2408_0001);

    // simultaneous fetch and load: data goes first
    access(1'b1, 1'b1, 32'hBFC0_0004, 32'h8000_1000, 4'd0, 32'd0, 0, 0, 0);

    // single-byte store
    access(1'b0, 1'b1, 32'd0, 32'h8000_1002, 4'b0100, 32'h00AB_0000, 0, 0, 1);
    check("t3_mem_byte", 32'(slave_mem[30'h2000_0400][23:16]), 32'hAB);

    // word store with AW accepted before W
    access(1'b0, 1'b1, 32'd0, 32'h8000_1010, 4'hF, 32'hDEAD_BEEF, 1, 4, 2);

    // reset while waiting for read data
    data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h8000_1030;
    n = 0;
    while (!axi.arvalid && n < 10) begin
      tick();
      n++;
    end
    check("t5_ar", 32'(axi.arvalid), 32'd1);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    check("t5_in_r", 32'(axi.rready), 32'd1);
    rst = 1'b1;
    tick();
    check("t5_rready", 32'({axi.rready, axi.arvalid}), 32'd0);
    check("t5_stall", 32'(stallreq), 32'd0);
    check("t5_inst_rdata", inst_sram_rdata, 32'd0);
    check("t5_data_rdata", data_sram_rdata, 32'd0);
    rst = 1'b0;
    data_sram_en = 1'b0;
    exp_inst_rd = 32'd0;
    exp_data_rd = 32'd0;
    tick();
    check("t5_idle", 32'({stallreq, axi.arvalid}), 32'd0);

    // back-to-back loads with enable held
    data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h8000_1020;
    exp_data_rd = ref_rd(30'h2000_0408);
    serve(1'b1, 32'h8000_1020, 4'd0, 32'd0, 0, 0, 0);
    check("t6_release", 32'(stallreq), 32'd0);
    check("t6_rdata_a", data_sram_rdata, exp_data_rd);
    tick();
    data_sram_addr = 32'h8000_1024;
    #1;
    check("t6_stall_again", 32'(stallreq), 32'd1);
    exp_data_rd = ref_rd(30'h2000_0409);
    serve(1'b1, 32'h8000_1024, 4'd0, 32'd0, 1, 1, 0);
    check("t6_release_b", 32'(stallreq), 32'd0);
    check("t6_rdata_b", data_sram_rdata, exp_data_rd);
    data_sram_en = 1'b0;
    tick();

    // randomized mixed traffic over a small address window
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 2);
      ie   = (kind != 1);
      de   = (kind != 0);
      ia   = 32'h8000_1000 | (32'($urandom_range(0, 7)) << 2);
      da   = 32'h8000_1000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      wen  = wen_tab[$urandom_range(0, 9)];
      wd   = $urandom;
      access(ie, de, ia, da, wen, wd,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
